// File: rtl/datapath_pkg.sv
// Shared datapath definitions: serial FSM states and default operand width.
package datapath_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/datapath_sub_slice.sv
// Single-bit combinational full subtractor: D = a - b - Bin, Bout = borrow.
module datapath_sub_slice (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = a ^ b ^ Bin;
  assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/datapath_serial_sub.sv
// Bit-serial subtractor, LSB first through one full-subtractor slice; Q = {borrow, a - b - Bin}.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow flag (ovf).
module datapath_serial_sub
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   Q
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, diff;
  logic             br;
  logic             d_c, bout_c, last_c, accept_c;
  logic [WIDTH-1:0] diff_nxt_c;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  datapath_sub_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .Bin  (br),
    .D    (d_c),
    .Bout (bout_c)
  );

  assign last_c     = (cnt == CW'(WIDTH - 1));
  assign accept_c   = load && (state != SHIFT);
  assign diff_nxt_c = (diff >> 1) | (WIDTH'(d_c) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; loads are only honoured outside SHIFT
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (last_c) state_next = DONE;
      DONE:    state_next = load ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial step, result and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      Q    <= '0;
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      diff <= '0;
      br   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (accept_c) begin
        a_sh <= a;
        b_sh <= b;
        br   <= Bin;
        cnt  <= '0;
        diff <= '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        br   <= bout_c;
        diff <= diff_nxt_c;
        cnt  <= cnt + CW'(1);
        if (last_c) begin
          Q <= {bout_c, diff_nxt_c};
`ifdef SERIAL_SUB_OVF_EN
          ovf <= (a_msb ^ b_msb) & (a_msb ^ diff_nxt_c[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule
